// File: rtl/sop_pkg.sv
// Monomial index map and pair/triple tables shared by the SOP pipeline.
// Index order: a,b,c,d, ab,ac,ad,bc,bd,cd, abc,abd,acd,bcd, abcd.
package sop_pkg;
   localparam int SOP_W = 15;
   localparam int N_LO  = 10;
   localparam int N_HI  = 5;

   localparam int IDX_A    = 0;
   localparam int IDX_B    = 1;
   localparam int IDX_C    = 2;
   localparam int IDX_D    = 3;
   localparam int IDX_AB   = 4;
   localparam int IDX_AC   = 5;
   localparam int IDX_AD   = 6;
   localparam int IDX_BC   = 7;
   localparam int IDX_BD   = 8;
   localparam int IDX_CD   = 9;
   localparam int IDX_ABC  = 10;
   localparam int IDX_ABD  = 11;
   localparam int IDX_ACD  = 12;
   localparam int IDX_BCD  = 13;
   localparam int IDX_ABCD = 14;

   localparam int PAIR_I   [6] = '{0, 0, 0, 1, 1, 2};
   localparam int PAIR_J   [6] = '{1, 2, 3, 2, 3, 3};
   localparam int PAIR_IDX [6] = '{IDX_AB, IDX_AC, IDX_AD, IDX_BC, IDX_BD, IDX_CD};

   localparam int TRIP_I   [4] = '{0, 0, 0, 1};
   localparam int TRIP_J   [4] = '{1, 1, 2, 2};
   localparam int TRIP_K   [4] = '{2, 3, 3, 3};
   localparam int TRIP_IDX [4] = '{IDX_ABC, IDX_ABD, IDX_ACD, IDX_BCD};

   function automatic int pair_idx(int i, int j);
      int idx;
      idx = IDX_AB;
      for (int p = 0; p < 6; p++) begin
         if ((PAIR_I[p] == i && PAIR_J[p] == j) || (PAIR_I[p] == j && PAIR_J[p] == i)) begin
            idx = PAIR_IDX[p];
         end
      end
      return idx;
   endfunction
endpackage

// File: rtl/sop_lane_core.sv
// Combinational per-lane SOP: degree-1/2 terms from g/h, degree-3/4 terms from
// g/h plus the already-registered degree-2 results in y_lo.
module sop_lane_core
   import sop_pkg::*;
(
   input  logic [SOP_W-1:0] g,
   input  logic [SOP_W-1:0] h,
   input  logic [N_LO-1:0]  y_lo,
   output logic [N_LO-1:0]  y_lo_d,
   output logic [N_HI-1:0]  y_hi
);
   logic [3:0] y3;
   logic       unused_bits;

   always_comb begin
      y_lo_d = '0;
      y_lo_d[IDX_D:IDX_A] = g[IDX_D:IDX_A];
      for (int p = 0; p < 6; p++) begin
         y_lo_d[PAIR_IDX[p]] = g[PAIR_IDX[p]]
                             ^ (g[PAIR_I[p]] & h[PAIR_J[p]])
                             ^ (g[PAIR_J[p]] & h[PAIR_I[p]]);
      end
   end

   // y3[t] follows TRIP_IDX order (abc, abd, acd, bcd); abcd reuses bcd/acd.
   always_comb begin
      y3 = '0;
      for (int t = 0; t < 4; t++) begin
         y3[t] = (y_lo[pair_idx(TRIP_I[t], TRIP_J[t])] & h[TRIP_K[t]])
               ^ g[TRIP_IDX[t]]
               ^ (g[pair_idx(TRIP_I[t], TRIP_K[t])] & h[TRIP_J[t]])
               ^ (g[pair_idx(TRIP_J[t], TRIP_K[t])] & h[TRIP_I[t]])
               ^ (g[TRIP_K[t]] & h[pair_idx(TRIP_I[t], TRIP_J[t])]);
      end
      y_hi = {(y3[3] & h[IDX_A]) ^ (y3[2] & h[IDX_B]) ^ (y_lo[IDX_CD] & h[IDX_AB])
              ^ (g[IDX_ABD] & h[IDX_C]) ^ (g[IDX_ABC] & h[IDX_D])
              ^ (g[IDX_AB] & h[IDX_CD]) ^ g[IDX_ABCD],
              y3};
   end

   assign unused_bits = ^{h[IDX_AD], h[IDX_BD], h[SOP_W-1:IDX_ABC],
                          y_lo[IDX_D:IDX_A], y_lo[IDX_AD], y_lo[IDX_BD]};
endmodule

// File: rtl/sop_domain_pipe.sv
// Two-stage registered per-domain sum-of-products with valid/ready back-pressure.
// Optional output refresh with port rnd when SOP_REFRESH_EN is defined.
module sop_domain_pipe #(
   parameter int LANES = 1,
   parameter int SOP_W = 15
) (
   input  logic                   clk,
   input  logic                   rst_n,
   input  logic                   in_valid,
   output logic                   in_ready,
   input  logic [LANES*SOP_W-1:0] gi,
   input  logic [LANES*SOP_W-1:0] hi,
`ifdef SOP_REFRESH_EN
   input  logic [LANES*SOP_W-1:0] rnd,
`endif
   output logic                   out_valid,
   input  logic                   out_ready,
   output logic [LANES*SOP_W-1:0] out_share
);
   import sop_pkg::*;

   localparam int LW = LANES * SOP_W;
   localparam int YW = LANES * N_LO;
   localparam int HW = LANES * N_HI;

   logic          s1_v_q, s1_v_d;
   logic          out_valid_q, out_valid_d;
   logic [LW-1:0] g_q, g_d, h_q, h_d;
   logic [YW-1:0] ylo_q, ylo_d;
   logic [LW-1:0] out_share_q, out_share_d;
   logic [YW-1:0] ylo_a;
   logic [HW-1:0] yhi_b;
   logic [LW-1:0] sop_b, sop_out;
   logic [HW-1:0] unused_hi_a;
   logic [YW-1:0] unused_lo_b;
   logic          ld_a, ld_b;

   for (genvar l = 0; l < LANES; l++) begin : g_lane
      sop_lane_core u_core_a (
         .g      (gi[l*SOP_W +: SOP_W]),
         .h      (hi[l*SOP_W +: SOP_W]),
         .y_lo   ({N_LO{1'b0}}),
         .y_lo_d (ylo_a[l*N_LO +: N_LO]),
         .y_hi   (unused_hi_a[l*N_HI +: N_HI])
      );
      sop_lane_core u_core_b (
         .g      (g_q[l*SOP_W +: SOP_W]),
         .h      (h_q[l*SOP_W +: SOP_W]),
         .y_lo   (ylo_q[l*N_LO +: N_LO]),
         .y_lo_d (unused_lo_b[l*N_LO +: N_LO]),
         .y_hi   (yhi_b[l*N_HI +: N_HI])
      );
      assign sop_b[l*SOP_W +: SOP_W] = {yhi_b[l*N_HI +: N_HI], ylo_q[l*N_LO +: N_LO]};
   end

`ifdef SOP_REFRESH_EN
   // Linear terms stay unmasked; the partner domain applies the same rnd.
   localparam logic [SOP_W-1:0] REFRESH_MASK = 15'h7FF0;
   assign sop_out = sop_b ^ (rnd & {LANES{REFRESH_MASK}});
`else
   assign sop_out = sop_b;
`endif

   always_comb begin
      ld_b        = s1_v_q && (!out_valid_q || out_ready);
      in_ready    = !s1_v_q || ld_b;
      ld_a        = in_valid && in_ready;
      s1_v_d      = s1_v_q;
      out_valid_d = out_valid_q;
      g_d         = g_q;
      h_d         = h_q;
      ylo_d       = ylo_q;
      out_share_d = out_share_q;
      if (ld_a) begin
         s1_v_d = 1'b1;
         g_d    = gi;
         h_d    = hi;
         ylo_d  = ylo_a;
      end else if (ld_b) begin
         s1_v_d = 1'b0;
      end
      if (ld_b) begin
         out_valid_d = 1'b1;
         out_share_d = sop_out;
      end else if (out_ready) begin
         out_valid_d = 1'b0;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         s1_v_q      <= 1'b0;
         out_valid_q <= 1'b0;
         g_q         <= '0;
         h_q         <= '0;
         ylo_q       <= '0;
         out_share_q <= '0;
      end else begin
         s1_v_q      <= s1_v_d;
         out_valid_q <= out_valid_d;
         g_q         <= g_d;
         h_q         <= h_d;
         ylo_q       <= ylo_d;
         out_share_q <= out_share_d;
      end
   end

   assign out_valid = out_valid_q;
   assign out_share = out_share_q;
endmodule

// File: tb/tb_sop_domain_pipe.sv
// Scoreboard bench: two 4-lane domain instances, reference SOP model and
// recombination check against the plain monomials of the unmasked inputs.
module tb_sop_domain_pipe;
   localparam int LANES = 4;
   localparam int LW    = LANES * 15;
   localparam int VMASK [15] = '{1, 2, 4, 8, 3, 5, 9, 6, 10, 12, 7, 11, 13, 14, 15};
   localparam logic [LW-1:0] LANE2_MASK = {15'h0, 15'h7FFF, 30'h0};

   logic          clk = 1'b0;
   logic          rst_n = 1'b0;
   logic          in_valid = 1'b0;
   logic          out_ready = 1'b0;
   logic [LW-1:0] gi0 = '0, hi0 = '0, gi1 = '0, hi1 = '0;
   logic          in_ready0, in_ready1, out_valid0, out_valid1;
   logic [LW-1:0] out_share0, out_share1;
`ifdef SOP_REFRESH_EN
   logic [LW-1:0] rnd = '0;
`endif

   typedef struct {
      logic [LW-1:0] e0;
      logic [LW-1:0] e1;
      logic [LW-1:0] plain;
      bit            rc;
   } exp_t;

   exp_t          exp_q[$];
   logic [LW-1:0] got_q[$];
   int            checks = 0;
   int            failures = 0;

   always #5 clk = ~clk;

   sop_domain_pipe #(.LANES(LANES), .SOP_W(15)) dut0 (
      .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready0),
      .gi(gi0), .hi(hi0),
`ifdef SOP_REFRESH_EN
      .rnd(rnd),
`endif
      .out_valid(out_valid0), .out_ready(out_ready), .out_share(out_share0));

   sop_domain_pipe #(.LANES(LANES), .SOP_W(15)) dut1 (
      .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready1),
      .gi(gi1), .hi(hi1),
`ifdef SOP_REFRESH_EN
      .rnd(rnd),
`endif
      .out_valid(out_valid1), .out_ready(out_ready), .out_share(out_share1));

   task automatic check(input string name, input logic [LW-1:0] act, input logic [LW-1:0] req);
      checks++;
      if (act !== req) begin
         failures++;
         $display("FAIL %s: got %h expected %h", name, act, req);
      end
   endtask

   task automatic check1(input string name, input logic act, input logic req);
      checks++;
      if (act !== req) begin
         failures++;
         $display("FAIL %s: got %b expected %b", name, act, req);
      end
   endtask

   function automatic int idx_of(int m);
      for (int k = 0; k < 15; k++) if (VMASK[k] == m) return k;
      return 0;
   endfunction

   // Plain monomials of one 4-bit variable vector (bit0=a .. bit3=d).
   function automatic logic [14:0] mono(logic [3:0] x);
      logic [14:0] m;
      for (int k = 0; k < 15; k++) m[k] = ((32'(x) & VMASK[k]) == VMASK[k]);
      return m;
   endfunction

   function automatic logic [LW-1:0] mono_all(logic [15:0] x);
      logic [LW-1:0] r;
      for (int l = 0; l < LANES; l++) r[l*15 +: 15] = mono(x[l*4 +: 4]);
      return r;
   endfunction

   function automatic logic [14:0] sop_ref(logic [14:0] g, logic [14:0] h);
      logic [14:0] y;
      int p, t, pij, pik, pjk;
      y = '0;
      for (int k = 0; k < 4; k++) y[k] = g[k];
      for (int i = 0; i < 4; i++)
         for (int j = i + 1; j < 4; j++) begin
            p = idx_of((1 << i) | (1 << j));
            y[p] = g[p] ^ (g[i] & h[j]) ^ (g[j] & h[i]);
         end
      for (int i = 0; i < 4; i++)
         for (int j = i + 1; j < 4; j++)
            for (int k = j + 1; k < 4; k++) begin
               t   = idx_of((1 << i) | (1 << j) | (1 << k));
               pij = idx_of((1 << i) | (1 << j));
               pik = idx_of((1 << i) | (1 << k));
               pjk = idx_of((1 << j) | (1 << k));
               y[t] = (y[pij] & h[k]) ^ g[t] ^ (g[pik] & h[j]) ^ (g[pjk] & h[i]) ^ (g[k] & h[pij]);
            end
      y[14] = (y[13] & h[0]) ^ (y[12] & h[1]) ^ (y[9] & h[4]) ^ (g[11] & h[2])
            ^ (g[10] & h[3]) ^ (g[4] & h[9]) ^ g[14];
      return y;
   endfunction

   function automatic logic [LW-1:0] ref_all(logic [LW-1:0] g, logic [LW-1:0] h);
      logic [LW-1:0] r;
      for (int l = 0; l < LANES; l++) r[l*15 +: 15] = sop_ref(g[l*15 +: 15], h[l*15 +: 15]);
`ifdef SOP_REFRESH_EN
      r = r ^ (rnd & {LANES{15'h7FF0}});
`endif
      return r;
   endfunction

   function automatic logic [LW-1:0] rand_lw();
      logic [63:0] r;
      r = {$urandom(), $urandom()};
      return r[LW-1:0];
   endfunction

   task automatic send(input logic [LW-1:0] g0, input logic [LW-1:0] h0,
                       input logic [LW-1:0] g1, input logic [LW-1:0] h1,
                       input logic [LW-1:0] plain, input logic [LW-1:0] e0,
                       input bit rc, input bit rand_rdy);
      exp_t e;
      bit   accepted;
      gi0 = g0; hi0 = h0; gi1 = g1; hi1 = h1;
      in_valid = 1'b1;
      accepted = 1'b0;
      for (int n = 0; n < 200 && !accepted; n++) begin
         if (rand_rdy) out_ready = ($urandom_range(0, 3) != 0);
         @(negedge clk);
         if (in_ready0) begin
            accepted = 1'b1;
            check1("in_ready_sync", in_ready1, 1'b1);
            e.e0 = e0; e.e1 = ref_all(g1, h1); e.plain = plain; e.rc = rc;
            exp_q.push_back(e);
         end
         @(posedge clk); #1;
      end
      in_valid = 1'b0;
      if (!accepted) begin
         checks++; failures++;
         $display("FAIL send_timeout: in_ready stayed 0 for 200 cycles, expected 1");
      end
   endtask

   task automatic idle(input int n, input bit rand_rdy);
      for (int i = 0; i < n; i++) begin
         if (rand_rdy) out_ready = ($urandom_range(0, 3) != 0);
         @(posedge clk); #1;
      end
   endtask

   task automatic drain();
      int n;
      out_ready = 1'b1;
      n = 0;
      while (exp_q.size() != 0 && n < 100) begin
         @(posedge clk); #1;
         n++;
      end
      if (exp_q.size() != 0) begin
         checks++; failures++;
         $display("FAIL drain_timeout: %0d results outstanding, expected 0", exp_q.size());
      end
   endtask

   // Monitor: pops one expectation per completed output transfer.
   initial begin
      exp_t e;
      forever begin
         @(negedge clk);
         if (rst_n && out_valid0 && out_ready) begin
            got_q.push_back(out_share0);
            check1("out_valid_sync", out_valid1, 1'b1);
            if (exp_q.size() == 0) begin
               checks++; failures++;
               $display("FAIL unexpected_output: got %h with empty scoreboard", out_share0);
            end else begin
               e = exp_q.pop_front();
               check("dom0_share", out_share0, e.e0);
               check("dom1_share", out_share1, e.e1);
               if (e.rc) check("recombine", out_share0 ^ out_share1, e.plain);
            end
         end
      end
   end

   initial begin
      #600000;
      $display("FAIL watchdog: simulation exceeded time limit");
      $fatal(1, "watchdog");
   end

   initial begin
      logic [LW-1:0] g, h, g2, ev0, ev1, diff;
      logic [15:0]   x0, x1;
      int            n;

      repeat (3) @(posedge clk);
      @(negedge clk);
      check1("reset_out_valid", out_valid0, 1'b0);
      check("reset_out_share", out_share0, '0);
      check1("reset_in_ready", in_ready0, 1'b1);
      #3 rst_n = 1'b1;
      @(posedge clk); #1;
      out_ready = 1'b1;

      send(60'h1, 60'h2, '0, '0, '0, 60'h11, 1'b0, 1'b0);
      g = {LANES{15'h7FFF}};
      send(g, '0, '0, '0, '0, g, 1'b0, 1'b0);
      send('0, rand_lw(), '0, '0, '0, '0, 1'b0, 1'b0);
      drain();

      out_ready = 1'b0;
      g = rand_lw(); h = rand_lw(); ev0 = ref_all(g, h);
      send(g, h, '0, '0, '0, ev0, 1'b0, 1'b0);
      g2 = rand_lw(); ev1 = ref_all(g2, h);
      send(g2, h, '0, '0, '0, ev1, 1'b0, 1'b0);
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         check1("bp_in_ready_low", in_ready0, 1'b0);
         check("bp_hold_share", out_share0, ev0);
      end
      @(posedge clk); #1;
      out_ready = 1'b1;
      g = rand_lw(); h = rand_lw();
      send(g, h, '0, '0, '0, ref_all(g, h), 1'b0, 1'b0);
      g = rand_lw(); h = rand_lw();
      send(g, h, '0, '0, '0, ref_all(g, h), 1'b0, 1'b0);
      drain();

      out_ready = 1'b0;
      g = rand_lw() | 60'h1; h = rand_lw();
      send(g, h, '0, '0, '0, ref_all(g, h), 1'b0, 1'b0);
      send(g, h, '0, '0, '0, ref_all(g, h), 1'b0, 1'b0);
      #2 rst_n = 1'b0;
      #1;
      check1("rst_out_valid", out_valid0, 1'b0);
      check("rst_out_share", out_share0, '0);
      check1("rst_in_ready", in_ready0, 1'b1);
      exp_q.delete();
      repeat (2) @(posedge clk);
      #3 rst_n = 1'b1;
      @(negedge clk);
      check1("post_rst_in_ready", in_ready0, 1'b1);
      check1("post_rst_out_valid", out_valid0, 1'b0);
      @(posedge clk); #1;
      out_ready = 1'b1;

      got_q.delete();
      g = rand_lw(); h = rand_lw();
      send(g, h, '0, '0, '0, ref_all(g, h), 1'b0, 1'b0);
      g2 = (g & ~LANE2_MASK) | (rand_lw() & LANE2_MASK);
      g2[30] = ~g[30];
      send(g2, h, '0, '0, '0, ref_all(g2, h), 1'b0, 1'b0);
      drain();
      n = got_q.size();
      if (n < 2) begin
         checks++; failures++;
         $display("FAIL lane_iso_count: got %0d outputs, expected 2", n);
      end else begin
         diff = got_q[n-1] ^ got_q[n-2];
         check("lane_iso_other", diff & ~LANE2_MASK, '0);
         check1("lane_iso_lane2", diff[30], 1'b1);
      end

`ifdef SOP_REFRESH_EN
      rnd = rand_lw();
`endif
      for (int it = 0; it < 300; it++) begin
         if ($urandom_range(0, 3) == 0) idle($urandom_range(1, 2), 1'b1);
         if ($urandom_range(0, 2) != 0) begin
            x0 = 16'($urandom()); x1 = 16'($urandom());
            g = mono_all(x0); h = mono_all(x1);
            send(g, h, h, '0, mono_all(x0 ^ x1), ref_all(g, h), 1'b1, 1'b1);
         end else begin
            g = rand_lw(); h = rand_lw();
            send(g, h, rand_lw(), rand_lw(), '0, ref_all(g, h), 1'b0, 1'b1);
         end
      end
      drain();

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
